// File: rtl/tnn_neuron_accum.sv
// Ternary-neuron accumulator: sums (pos - neg) popcount differences over
// NUM_BEATS beats, thresholds the result into {-1, 0, +1} and presents it
// on a valid/ready handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACCUM | accepting beats; cnt tracks position within the frame
//   HOLD  | result held on out_trit/out_sum until downstream takes it
module tnn_neuron_accum #(
    parameter int NUM_BEATS = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       pc_pos,
    input  logic [4:0]       pc_neg,
    input  logic [ACC_W-1:0] thr_hi,
    input  logic [ACC_W-1:0] thr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_trit,
    output logic [ACC_W-1:0] out_sum
);

    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BEATS - 1);

    // Worst-case sum magnitude is 16 per beat; the accumulator must hold it
    // without wrapping since there is no saturation.
    if (NUM_BEATS < 1) begin : g_bad_num_beats
        $error("tnn_neuron_accum: NUM_BEATS must be at least 1");
    end
    if ((2 ** (ACC_W - 1)) <= (16 * NUM_BEATS)) begin : g_bad_acc_w
        $error("tnn_neuron_accum: ACC_W too narrow for 16*NUM_BEATS");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                   state;
    logic        [CNT_W-1:0]  cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  thr_hi_q;
    logic signed [ACC_W-1:0]  thr_lo_q;

    logic        [4:0]        pos_c;
    logic        [4:0]        neg_c;
    logic signed [5:0]        d6;
    logic signed [ACC_W-1:0]  d_ext;
    logic                     first_beat;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  s;
    logic signed [ACC_W-1:0]  hi_eff;
    logic signed [ACC_W-1:0]  lo_eff;
    logic        [1:0]        trit;

    // Popcounts of a 16-input slice cannot legitimately exceed 16; clamp
    // anything larger so a corrupt input cannot push the sum out of range.
    assign pos_c      = (pc_pos > 5'd16) ? 5'd16 : pc_pos;
    assign neg_c      = (pc_neg > 5'd16) ? 5'd16 : pc_neg;
    assign d6         = $signed({1'b0, pos_c}) - $signed({1'b0, neg_c});
    assign d_ext      = {{(ACC_W - 6){d6[5]}}, d6};

    // The first beat of a frame starts from zero and uses the thresholds
    // presented alongside it, which matters when NUM_BEATS is 1.
    assign first_beat = (cnt == '0);
    assign base       = first_beat ? '0 : acc;
    assign s          = base + d_ext;
    assign hi_eff     = first_beat ? thr_hi : thr_hi_q;
    assign lo_eff     = first_beat ? thr_lo : thr_lo_q;

    // Ternary decision; +1 wins when the thresholds overlap.
    always_comb begin
        trit = 2'b00;
        if (s >= hi_eff) begin
            trit = 2'b01;
        end else if (s <= lo_eff) begin
            trit = 2'b11;
        end
    end

    // in_ready is a state decode, gated by reset so it reads 0 while reset
    // is held and 1 as soon as it is released.
    assign in_ready  = rst_n && (state == ACCUM);
    assign out_valid = (state == HOLD);

    // Frame sequencing: accumulate beats, latch the result, wait for pickup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACCUM;
            cnt      <= '0;
            acc      <= '0;
            thr_hi_q <= '0;
            thr_lo_q <= '0;
            out_trit <= 2'b00;
            out_sum  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (first_beat) begin
                            thr_hi_q <= thr_hi;
                            thr_lo_q <= thr_lo;
                        end
                        if (cnt == LAST) begin
                            out_sum  <= s;
                            out_trit <= trit;
                            cnt      <= '0;
                            state    <= HOLD;
                        end else begin
                            acc <= s;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Bench for tnn_neuron_accum: directed and random frames checked against a
// behavioural sum/threshold model; a second instance covers NUM_BEATS = 1.
module tb_tnn_neuron_accum;

    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_in_valid, b_in_valid, out_ready;
    logic [4:0]       pc_pos, pc_neg;
    logic [ACC_W-1:0] thr_hi, thr_lo;

    logic             a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [1:0]       a_out_trit, b_out_trit;
    logic [ACC_W-1:0] a_out_sum, b_out_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int q_pos[$];
    int q_neg[$];

    tnn_neuron_accum #(.NUM_BEATS(4), .ACC_W(ACC_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_trit(a_out_trit), .out_sum(a_out_sum)
    );

    tnn_neuron_accum #(.NUM_BEATS(1), .ACC_W(ACC_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_trit(b_out_trit), .out_sum(b_out_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp16(input int v);
        return (v > 16) ? 16 : v;
    endfunction

    function automatic int model_sum();
        int acc_m = 0;
        foreach (q_pos[i]) acc_m += clamp16(q_pos[i]) - clamp16(q_neg[i]);
        return acc_m;
    endfunction

    // Trit encoding: +1 -> 2'b01, -1 -> 2'b11, 0 -> 2'b00.
    function automatic int model_trit(input int sm, input int hi, input int lo);
        if (sm >= hi) return 1;
        if (sm <= lo) return 3;
        return 0;
    endfunction

    task automatic a_beat(input int p, input int n, input int gap);
        for (int g = 0; g < gap; g++) begin
            a_in_valid = 1'b0;
            pc_pos = 5'($urandom);
            pc_neg = 5'($urandom);
            tick();
        end
        pc_pos = 5'(p);
        pc_neg = 5'(n);
        a_in_valid = 1'b1;
        check("a_in_ready_beat", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        q_pos.push_back(p);
        q_neg.push_back(n);
    endtask

    // One full 4-beat frame on dut_a. Thresholds change randomly after the
    // first beat (hi to hi_late); the model only ever uses hi/lo.
    task automatic a_frame(input int p[4], input int n[4], input int hi, input int lo,
                           input int hi_late, input int max_gap, input int hold);
        int es, et;
        q_pos.delete();
        q_neg.delete();
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            thr_hi = (i == 0) ? ACC_W'(hi) : ACC_W'(hi_late);
            thr_lo = (i == 0) ? ACC_W'(lo) : ACC_W'($urandom);
            a_beat(p[i], n[i], int'($urandom_range(0, max_gap)));
            if (i < 3) check("a_valid_midframe", a_out_valid, 0);
        end
        es = model_sum();
        et = model_trit(es, hi, lo);
        check("a_out_valid", a_out_valid, 1);
        check("a_in_ready_hold", a_in_ready, 0);
        check("a_out_sum", $signed(a_out_sum), es);
        check("a_out_trit", a_out_trit, et);
        for (int h = 0; h < hold; h++) begin
            a_in_valid = 1'($urandom);
            pc_pos = 5'($urandom);
            pc_neg = 5'($urandom);
            tick();
            check("a_hold_valid", a_out_valid, 1);
            check("a_hold_in_ready", a_in_ready, 0);
            check("a_hold_sum", $signed(a_out_sum), es);
            check("a_hold_trit", a_out_trit, et);
        end
        a_in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("a_after_hs_valid", a_out_valid, 0);
        check("a_after_hs_ready", a_in_ready, 1);
    endtask

    initial begin
        int rp[4];
        int rn[4];
        int hi, lo, es;

        rst_n = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        out_ready = 1'b1;
        pc_pos = '0;
        pc_neg = '0;
        thr_hi = '0;
        thr_lo = '0;
        tick();
        tick();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_sum", a_out_sum, 0);
        check("rst_out_trit", a_out_trit, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", a_in_ready, 1);

        // Basic frame: 8 + 16 + 0 - 3 = 21 >= 20.
        a_frame('{10, 16, 5, 0}, '{2, 0, 5, 3}, 20, -20, 20, 0, 0);
        check("basic_sum_21", $signed(a_out_sum), 21);
        // All negative, then a zero frame proves acc clears between frames.
        a_frame('{0, 0, 0, 0}, '{16, 16, 16, 16}, 20, -10, 20, 0, 0);
        a_frame('{8, 8, 8, 8}, '{8, 8, 8, 8}, 20, -10, 20, 0, 0);
        // Backpressure for 5 cycles with junk on the inputs.
        a_frame('{3, 9, 12, 7}, '{1, 0, 4, 2}, 20, -20, 20, 0, 5);
        a_frame('{8, 8, 8, 8}, '{1, 1, 1, 1}, 20, -20, 20, 0, 0);
        // Gaps plus a late threshold change that must not take effect.
        a_frame('{10, 16, 5, 0}, '{2, 0, 5, 3}, 20, -20, 100, 3, 0);
        // Clamp on input and +1 priority over overlapping thresholds.
        a_frame('{20, 0, 0, 0}, '{0, 0, 0, 0}, 16, 16, 16, 0, 0);

        // Random frames against the model.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 4; i++) begin
                rp[i] = int'($urandom_range(0, 31));
                rn[i] = int'($urandom_range(0, 31));
            end
            hi = int'($urandom_range(0, 80)) - 40;
            lo = int'($urandom_range(0, 80)) - 40;
            a_frame(rp, rn, hi, lo, int'($urandom_range(0, 255)),
                    3, int'($urandom_range(0, 2)));
        end

        // Reset mid-frame discards the partial beats.
        q_pos.delete();
        q_neg.delete();
        out_ready = 1'b1;
        a_beat(16, 0, 0);
        a_beat(16, 0, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_in_ready", a_in_ready, 0);
        check("mid_rst_sum", a_out_sum, 0);
        check("mid_rst_trit", a_out_trit, 0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", a_in_ready, 1);
        a_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 20, -20, 20, 0, 0);
        check("post_rst_sum_4", $signed(a_out_sum), 4);

        // Reset during HOLD drops the pending result.
        q_pos.delete();
        q_neg.delete();
        out_ready = 1'b0;
        thr_hi = 8'd20;
        thr_lo = -8'sd20;
        for (int i = 0; i < 4; i++) a_beat(5, 1, 0);
        check("hold_pre_rst_valid", a_out_valid, 1);
        check("hold_pre_rst_sum", $signed(a_out_sum), model_sum());
        rst_n = 1'b0;
        tick();
        check("hold_rst_valid", a_out_valid, 0);
        rst_n = 1'b1;
        tick();
        check("hold_rel_in_ready", a_in_ready, 1);
        check("hold_rel_valid", a_out_valid, 0);

        // NUM_BEATS = 1: result one cycle after the single beat.
        out_ready = 1'b1;
        pc_pos = 5'd3;
        pc_neg = 5'd1;
        thr_hi = 8'd2;
        thr_lo = -8'sd5;
        b_in_valid = 1'b1;
        check("b_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        check("b_out_valid", b_out_valid, 1);
        check("b_in_ready_hold", b_in_ready, 0);
        check("b_out_sum", $signed(b_out_sum), 2);
        check("b_out_trit", b_out_trit, 1);
        tick();
        check("b_after_hs_valid", b_out_valid, 0);
        check("b_after_hs_ready", b_in_ready, 1);
        for (int k = 0; k < 12; k++) begin
            q_pos.delete();
            q_neg.delete();
            q_pos.push_back(int'($urandom_range(0, 31)));
            q_neg.push_back(int'($urandom_range(0, 31)));
            hi = int'($urandom_range(0, 32)) - 16;
            lo = int'($urandom_range(0, 32)) - 16;
            pc_pos = 5'(q_pos[0]);
            pc_neg = 5'(q_neg[0]);
            thr_hi = ACC_W'(hi);
            thr_lo = ACC_W'(lo);
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            es = model_sum();
            check("b_rand_valid", b_out_valid, 1);
            check("b_rand_sum", $signed(b_out_sum), es);
            check("b_rand_trit", b_out_trit, model_trit(es, hi, lo));
            tick();
            check("b_rand_ready", b_in_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
